// File: rtl/key_debouncer.sv
// Per-key push-button debouncer: stable level, press/release pulses and a press counter.
// Define KEY_DEBOUNCER_SYNC_EN to add a 2-flop input synchronizer (required on hardware).
module key_debouncer #(
  parameter int unsigned N_KEYS          = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key_n,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [7:0]        press_count
);

  typedef enum logic [1:0] {
    StReleased,
    StWaitPress,
    StPressed,
    StWaitRelease
  } state_e;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

  state_e            state_q [N_KEYS];
  state_e            state_d [N_KEYS];
  logic [CNT_W-1:0]  cnt_q   [N_KEYS];
  logic [CNT_W-1:0]  cnt_d   [N_KEYS];
  logic [N_KEYS-1:0] sample;
  logic [N_KEYS-1:0] level_d;
  logic [N_KEYS-1:0] press_d;
  logic [N_KEYS-1:0] release_d;
  logic [7:0]        count_d;

`ifdef KEY_DEBOUNCER_SYNC_EN
  logic [N_KEYS-1:0] sync1_q;
  logic [N_KEYS-1:0] sync2_q;

  // Reset to 1 so an idle (released) button looks released from the first cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
    end
  end

  assign sample = ~sync2_q;
`else
  assign sample = ~key_n;
`endif

  always_comb begin
    level_d   = key_level;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < int'(N_KEYS); i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      unique case (state_q[i])
        StReleased: begin
          if (sample[i]) begin
            state_d[i] = StWaitPress;
            cnt_d[i]   = CntOne;
          end
        end
        StWaitPress: begin
          if (!sample[i]) begin
            state_d[i] = StReleased;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CntLast) begin
            state_d[i] = StPressed;
            cnt_d[i]   = '0;
            level_d[i] = 1'b1;
            press_d[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CntOne;
          end
        end
        StPressed: begin
          if (!sample[i]) begin
            state_d[i] = StWaitRelease;
            cnt_d[i]   = CntOne;
          end
        end
        StWaitRelease: begin
          if (sample[i]) begin
            state_d[i] = StPressed;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CntLast) begin
            state_d[i]   = StReleased;
            cnt_d[i]     = '0;
            level_d[i]   = 1'b0;
            release_d[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CntOne;
          end
        end
        default: begin
          state_d[i] = StReleased;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  // The counter follows the registered press pulses, so it advances one cycle after each commit.
  always_comb begin
    count_d = press_count;
    for (int i = 0; i < int'(N_KEYS); i++) begin
      count_d = count_d + 8'(key_press[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(N_KEYS); i++) begin
        state_q[i] <= StReleased;
        cnt_q[i]   <= '0;
      end
      key_level   <= '0;
      key_press   <= '0;
      key_release <= '0;
      press_count <= '0;
    end else begin
      for (int i = 0; i < int'(N_KEYS); i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      key_level   <= level_d;
      key_press   <= press_d;
      key_release <= release_d;
      press_count <= count_d;
    end
  end

endmodule

// File: tb/tb_key_debouncer.sv
// Scoreboard bench for key_debouncer: a run-length reference model queues expected outputs per
// clock, a monitor pops and compares them; directed scenarios are followed by random stimulus.
module tb_key_debouncer;

  localparam int NK = 2;
  localparam int DC = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [NK-1:0] key_n = '1;
  logic [NK-1:0] key_level;
  logic [NK-1:0] key_press;
  logic [NK-1:0] key_release;
  logic [7:0]    press_count;

  key_debouncer #(
    .N_KEYS         (NK),
    .DEBOUNCE_CYCLES(DC),
    .CNT_W          (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_n      (key_n),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .press_count(press_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NK-1:0] level;
    logic [NK-1:0] press;
    logic [NK-1:0] rel;
    logic [7:0]    count;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   pushed = 0;
  int   popped = 0;

  // Reference model: a level commits once DC consecutive samples disagree with it.
  logic [NK-1:0] m_level;
  logic [NK-1:0] m_press;
  logic [NK-1:0] m_rel;
  int            m_run[NK];
  int            m_count;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_level = '0;
    m_press = '0;
    m_rel   = '0;
    m_count = 0;
    for (int i = 0; i < NK; i++) m_run[i] = 0;
  endtask

  // Called at a negedge: drive one sample, predict the outputs after the next posedge.
  task automatic step(input logic [NK-1:0] kn);
    logic s;
    key_n   = kn;
    m_count = (m_count + $countones(m_press)) % 256;
    m_press = '0;
    m_rel   = '0;
    for (int i = 0; i < NK; i++) begin
      s = ~kn[i];
      if (s != m_level[i]) begin
        m_run[i]++;
        if (m_run[i] == DC) begin
          m_level[i] = s;
          if (s) m_press[i] = 1'b1;
          else m_rel[i] = 1'b1;
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    exp_q.push_back('{level: m_level, press: m_press, rel: m_rel, count: 8'(m_count)});
    pushed++;
    @(negedge clk);
  endtask

  task automatic hold(input logic [NK-1:0] kn, input int n);
    for (int k = 0; k < n; k++) step(kn);
  endtask

  // Called at a negedge with an empty queue: async reset mid-cycle, released at a later negedge.
  task automatic do_reset(input logic [NK-1:0] kn, input int cycles);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_level", 8'(key_level), 8'h00);
    chk("rst_press", 8'(key_press), 8'h00);
    chk("rst_release", 8'(key_release), 8'h00);
    chk("rst_count", press_count, 8'h00);
    model_reset();
    key_n = kn;
    repeat (cycles) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        popped++;
        chk("level", 8'(key_level), 8'(mon_e.level));
        chk("press", 8'(key_press), 8'(mon_e.press));
        chk("release", 8'(key_release), 8'(mon_e.rel));
        chk("count", press_count, mon_e.count);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NK-1:0] kn;
    model_reset();
    #2;
    rst_n = 1'b0;
    #1;
    chk("init_level", 8'(key_level), 8'h00);
    chk("init_press", 8'(key_press), 8'h00);
    chk("init_release", 8'(key_release), 8'h00);
    chk("init_count", press_count, 8'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Clean press of key 0, then release.
    hold(2'b10, 6);
    hold(2'b11, 6);
    // Bounce rejection: 3 low, 1 high, 3 low, high.
    hold(2'b10, 3);
    hold(2'b11, 1);
    hold(2'b10, 3);
    hold(2'b11, 5);
    // Simultaneous press and release.
    hold(2'b00, 6);
    hold(2'b11, 6);
    // Release-side bounce while pressed.
    hold(2'b10, 6);
    hold(2'b11, 3);
    hold(2'b10, 2);
    hold(2'b11, 6);
    // Counter wrap: 257 clean presses of key 1.
    for (int p = 0; p < 257; p++) begin
      hold(2'b01, DC);
      hold(2'b11, DC);
    end
    hold(2'b11, 2);
    // Reset at cycle 2 of a press run with the key still held.
    hold(2'b10, 2);
    do_reset(2'b10, 2);
    hold(2'b10, 7);
    hold(2'b11, 6);

    // Random stimulus with occasional resets.
    kn = '1;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < NK; b++) begin
        if ($urandom_range(0, (c / 500) % 2 == 0 ? 3 : 7) == 0) kn[b] = ~kn[b];
      end
      step(kn);
      if ($urandom_range(0, 599) == 0) do_reset(kn, $urandom_range(1, 3));
    end
    hold(2'b11, 8);

    @(posedge clk);
    #2;
    chk("queue_drained", 8'(exp_q.size()), 8'h00);
    chk("pops_match", 8'(pushed - popped), 8'h00);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
